// File: rtl/ascon_ad_ctrl.sv
// Purpose : Ascon associated-data absorber; XORs 64-bit AD words into x0, pads, and sequences the external permutation.
// Latency : ad_len=0 -> done one cycle after start; otherwise one handshake/pad cycle + PERM + permutation latency per block, then FINAL.
// Backpres: ad_ready only in ABSORB; AD words are held off while a permutation is outstanding.
//
// Ports   : clk, rst (async, active-low); start/ad_len/state_in request; ad_data/ad_valid/ad_ready AD stream
//           (first byte at [63:56]); perm_start/perm_state -> permutation, perm_done/perm_result <- permutation;
//           state_out/done/busy status. Optional abort input when ASCON_AD_ABORT_EN is defined.
// Macro   : ASCON_AD_ABORT_EN adds the abort input and its return-to-IDLE logic.
module ascon_ad_ctrl #(
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ASCON_AD_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [319:0]     state_in,
    input  logic [63:0]      ad_data,
    input  logic             ad_valid,
    output logic             ad_ready,
    output logic             perm_start,
    output logic [319:0]     perm_state,
    input  logic             perm_done,
    input  logic [319:0]     perm_result,
    output logic [319:0]     state_out,
    output logic             done,
    output logic             busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABSORB = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_PERM   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_FINAL  = 3'd5;

    logic [2:0]       fsm;
    logic [LEN_W-1:0] rem;
    logic             pad_done;
    logic [319:0]     st;
    logic [319:0]     st_out_q;
    logic             abort_req;

`ifdef ASCON_AD_ABORT_EN
    assign abort_req = abort && (fsm != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // Partial-word handling: keep the upper rem bytes, drop the rest, and
    // place the 0x80 pad byte right after the last valid byte. Only used
    // when rem < 8, so rem[2:0] is the full byte count.
    logic [5:0]  byte_sh;
    logic [63:0] keep_mask;
    logic [63:0] pad_bit;
    logic [63:0] part_word;
    logic        full_word;

    assign byte_sh   = {rem[2:0], 3'b000};
    assign keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> byte_sh);
    assign pad_bit   = 64'h8000_0000_0000_0000 >> byte_sh;
    assign part_word = (ad_data & keep_mask) | pad_bit;
    assign full_word = (rem >= LEN_W'(8));

    assign ad_ready   = (fsm == S_ABSORB) && !abort_req;
    assign perm_start = (fsm == S_PERM) && !abort_req;
    assign perm_state = st;
    assign done       = (fsm == S_FINAL) && !abort_req;
    assign busy       = (fsm != S_IDLE);

    // The finished state is presented during the done cycle itself and
    // captured into st_out_q at the end of it so it holds until the next done.
    assign state_out  = done ? (st ^ 320'd1) : st_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm      <= S_IDLE;
            rem      <= '0;
            pad_done <= 1'b0;
            st       <= '0;
            st_out_q <= '0;
        end else if (abort_req) begin
            fsm <= S_IDLE;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        st       <= state_in;
                        rem      <= ad_len;
                        pad_done <= 1'b0;
                        fsm      <= (ad_len == '0) ? S_FINAL : S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    if (ad_valid) begin
                        if (full_word) begin
                            st[319:256] <= st[319:256] ^ ad_data;
                            rem         <= rem - LEN_W'(8);
                        end else begin
                            st[319:256] <= st[319:256] ^ part_word;
                            rem         <= '0;
                            pad_done    <= 1'b1;
                        end
                        fsm <= S_PERM;
                    end
                end
                S_PAD: begin
                    // Length was a multiple of 8: padding gets its own block.
                    st[319:256] <= st[319:256] ^ 64'h8000_0000_0000_0000;
                    pad_done    <= 1'b1;
                    fsm         <= S_PERM;
                end
                S_PERM: begin
                    fsm <= S_WAIT;
                end
                S_WAIT: begin
                    if (perm_done) begin
                        st <= perm_result;
                        if (pad_done)
                            fsm <= S_FINAL;
                        else if (rem != '0)
                            fsm <= S_ABSORB;
                        else
                            fsm <= S_PAD;
                    end
                end
                S_FINAL: begin
                    st_out_q <= st ^ 320'd1;
                    fsm      <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_ad_ctrl.sv
// Purpose : Self-checking bench for ascon_ad_ctrl with a byte-level golden model and a behavioural permutation.
// Latency : permutation responder latency is configurable per vector.
// Backpres: AD source can present words every cycle or every other cycle.
`timescale 1ns/1ps
module tb_ascon_ad_ctrl;

    localparam int LEN_W = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] ad_len;
    logic [319:0]     state_in;
    logic [63:0]      ad_data;
    logic             ad_valid;
    logic             ad_ready;
    logic             perm_start;
    logic [319:0]     perm_state;
    logic             perm_done;
    logic [319:0]     perm_result;
    logic [319:0]     state_out;
    logic             done;
    logic             busy;
`ifdef ASCON_AD_ABORT_EN
    logic             abort;
`endif

    always #5 clk = ~clk;

    ascon_ad_ctrl #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ASCON_AD_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .ad_len     (ad_len),
        .state_in   (state_in),
        .ad_data    (ad_data),
        .ad_valid   (ad_valid),
        .ad_ready   (ad_ready),
        .perm_start (perm_start),
        .perm_state (perm_state),
        .perm_done  (perm_done),
        .perm_result(perm_result),
        .state_out  (state_out),
        .done       (done),
        .busy       (busy)
    );

    typedef struct {
        int          len;
        logic        tog;
        int          lat;
        logic [63:0] w0;
    } vec_t;

    typedef struct {
        logic [319:0] so;
        int           np;
        int           nh;
    } exp_t;

    vec_t         tbl [7];
    exp_t         sb [$];
    logic [63:0]  gw [64];
    logic [319:0] ops_a [256];

    int n_vec  = 0;
    int n_miss = 0;

    // Environment configuration, written only by the main process.
    int lat_cfg = 1;
    bit tog_cfg = 1'b0;
    int nw_cfg  = 0;
    int epoch   = 0;

    // Environment state, written only by the environment process.
    int n_perm = 0;
    int n_hs   = 0;
    int n_rdy  = 0;

    function automatic logic [319:0] perm_f(input logic [319:0] s);
        return {s[316:0], s[319:317]} ^ (s >> 7) ^ {5{64'h9E37_79B9_7F4A_7C15}};
    endfunction

    // Byte-oriented reference: build each padded block from the AD bytes.
    function automatic logic [319:0] golden(input logic [319:0] s_in, input int len);
        logic [319:0] s;
        logic [63:0]  blk;
        logic [7:0]   b;
        int           nblk;
        int           idx;
        s    = s_in;
        nblk = (len == 0) ? 0 : (len / 8 + 1);
        for (int k = 0; k < nblk; k++) begin
            blk = '0;
            for (int j = 0; j < 8; j++) begin
                idx = k * 8 + j;
                if (idx < len)       b = gw[idx / 8][63 - 8 * (idx % 8) -: 8];
                else if (idx == len) b = 8'h80;
                else                 b = 8'h00;
                blk[63 - 8 * j -: 8] = b;
            end
            s[319:256] = s[319:256] ^ blk;
            s = perm_f(s);
        end
        return s ^ 320'd1;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Permutation responder and AD source; everything changes on the falling edge.
    initial begin : env
        bit           pend;
        bit           phase;
        int           cnt;
        int           widx;
        int           seen;
        logic [319:0] op_q;
        pend = 1'b0; phase = 1'b0; cnt = 0; widx = 0; seen = 0; op_q = '0;
        perm_done = 1'b0; perm_result = '0; ad_valid = 1'b0; ad_data = '0;
        forever begin
            @(negedge clk);
            perm_done = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    perm_done   = 1'b1;
                    perm_result = perm_f(op_q);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (perm_start) begin
                pend = 1'b1;
                cnt  = lat_cfg;
                op_q = perm_state;
                ops_a[n_perm % 256] = perm_state;
                n_perm++;
            end
            if (epoch != seen) begin
                widx = 0;
                seen = epoch;
            end
            phase    = ~phase;
            ad_valid = (widx < nw_cfg) && (!tog_cfg || phase);
            if (ad_valid) ad_data = gw[widx];
            else          ad_data = {$urandom(), $urandom()};
            if (ad_ready) n_rdy++;
            if (ad_valid && ad_ready) begin
                widx++;
                n_hs++;
            end
        end
    end

    logic [319:0] last_so = '0;

    task automatic load_words(input logic [63:0] w0);
        for (int k = 0; k < 64; k++) gw[k] = {$urandom(), $urandom()};
        gw[0] = w0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [319:0] st;
        exp_t         e;
        exp_t         g;
        int           p0, h0, r0, cyc;
        bit           got;
        for (int k = 0; k < 10; k++) st[k * 32 +: 32] = $urandom();
        load_words(v.w0);
        lat_cfg = v.lat;
        tog_cfg = v.tog;
        nw_cfg  = (v.len + 7) / 8;
        epoch++;
        p0 = n_perm; h0 = n_hs; r0 = n_rdy;
        e.so = golden(st, v.len);
        e.np = (v.len == 0) ? 0 : (v.len / 8 + 1);
        e.nh = (v.len + 7) / 8;
        sb.push_back(e);
        ad_len   = LEN_W'(v.len);
        state_in = st;
        start    = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                got = 1'b1;
                g = sb.pop_front();
                chk("state_out", state_out, g.so);
                chk("perm_count", n_perm - p0, g.np);
                chk("handshakes", n_hs - h0, g.nh);
                chk("busy_in_final", busy, 1);
                if (v.len == 0) begin
                    chk("len0_latency", cyc, 1);
                    chk("len0_ready_cycles", n_rdy - r0, 0);
                end
                if (v.len == 3)
                    chk("len3_perm_operand", ops_a[p0 % 256],
                        st ^ {64'h0001_0280_0000_0000, 256'd0});
                if (v.len == 8) begin
                    chk("len8_op0", ops_a[p0 % 256], st ^ {gw[0], 256'd0});
                    chk("len8_op1", ops_a[(p0 + 1) % 256],
                        perm_f(st ^ {gw[0], 256'd0}) ^ {64'h8000_0000_0000_0000, 256'd0});
                end
                last_so = g.so;
                @(negedge clk);
                chk("done_width", done, 0);
                chk("busy_after_done", busy, 0);
                chk("state_out_hold", state_out, g.so);
            end
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout: len %0d got no done, required done", v.len);
            g = sb.pop_front();
        end
    endtask

    initial begin : main
        int   p0;
        int   cyc;
        int   dcount;
        vec_t zv;
        rst = 1'b0; start = 1'b0; ad_len = '0; state_in = '0;
`ifdef ASCON_AD_ABORT_EN
        abort = 1'b0;
`endif
        tbl[0] = '{0,   1'b0, 1, 64'h0123_4567_89AB_CDEF};
        tbl[1] = '{3,   1'b0, 1, 64'h0001_02FF_FFFF_FFFF};
        tbl[2] = '{8,   1'b0, 2, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[3] = '{32,  1'b1, 8, 64'h1111_2222_3333_4444};
        tbl[4] = '{15,  1'b1, 3, 64'hA5A5_5A5A_F0F0_0F0F};
        tbl[5] = '{17,  1'b0, 1, 64'h7777_8888_9999_AAAA};
        tbl[6] = '{511, 1'b0, 1, 64'h0F1E_2D3C_4B5A_6978};

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ready", ad_ready, 0);
        chk("reset_perm_start", perm_start, 0);
        chk("reset_done", done, 0);
        chk("reset_state_out", state_out, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset in the middle of a permutation, then a stale perm_done.
        load_words(64'h0);
        lat_cfg = 20; tog_cfg = 1'b0; nw_cfg = 2; epoch++;
        p0 = n_perm;
        ad_len = LEN_W'(16); state_in = {5{64'h5555_AAAA_0000_FFFF}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (n_perm == p0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_test_perm_issued", n_perm - p0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nw_cfg = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ad_ready, 0);
        chk("midrst_perm_start", perm_start, 0);
        chk("midrst_done", done, 0);
        chk("midrst_state_out", state_out, 0);
        chk("midrst_perm_state", perm_state, 0);
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (busy || done) dcount++;
        end
        chk("stale_perm_done_ignored", dcount, 0);
        chk("stale_perm_state", perm_state, 0);
        last_so = '0;
        zv = '{0, 1'b0, 1, 64'h0};
        run_vec(zv);

`ifdef ASCON_AD_ABORT_EN
        load_words(64'h0);
        lat_cfg = 4; tog_cfg = 1'b0; nw_cfg = 2; epoch++;
        ad_len = LEN_W'(16); state_in = {5{64'h1234_5678_9ABC_DEF0}}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!ad_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_absorb", cyc < 50, 1);
        nw_cfg = 0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);
        chk("abort_state_out", state_out, last_so);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
